// File: rtl/jeff_byte_serializer.sv
// jeff_byte_serializer: framed parallel-in serial-out transmitter.
// Ports: clk, rst_bar (async low), load_en_bar, d[WIDTH] in;
//        ready, busy, sout (idles high), done (1-cycle pulse) out.
module jeff_byte_serializer #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_bar,
   input  logic             load_en_bar,
   input  logic [WIDTH-1:0] d,
   output logic             ready,
   output logic             busy,
   output logic             sout,
   output logic             done
);

   localparam int BW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam logic [7:0]    CYC_LAST = 8'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic [7:0]       cyc_cnt;
   logic             cyc_end;

   assign cyc_end = (cyc_cnt == CYC_LAST);

   always_ff @(posedge clk or negedge rst_bar) begin
      if (!rst_bar) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         cyc_cnt <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!load_en_bar) begin
                  shreg   <= d;
                  cyc_cnt <= '0;
                  state   <= START;
               end
            end
            START: begin
               if (cyc_end) begin
                  cyc_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= DATA;
               end else begin
                  cyc_cnt <= cyc_cnt + 8'd1;
               end
            end
            DATA: begin
               if (cyc_end) begin
                  cyc_cnt <= '0;
                  shreg   <= shreg >> 1;
                  bit_cnt <= bit_cnt + BW'(1);
                  // last data bit has just finished its slot
                  if (bit_cnt == BIT_LAST)
                     state <= STOP;
               end else begin
                  cyc_cnt <= cyc_cnt + 8'd1;
               end
            end
            STOP: begin
               if (cyc_end) begin
                  cyc_cnt <= '0;
                  state   <= IDLE;
                  // lands in the first IDLE cycle, which is also
                  // the cycle where a back-to-back load is taken
                  done    <= 1'b1;
               end else begin
                  cyc_cnt <= cyc_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // decoded from registers only, so reset forces the line high at once
   always_comb begin
      sout = 1'b1;
      unique case (state)
         START:   sout = 1'b0;
         DATA:    sout = shreg[0];
         default: sout = 1'b1;
      endcase
   end

   assign ready = (state == IDLE);
   assign busy  = ~ready;

endmodule

// File: tb/tb_jeff_byte_serializer.sv
// Bench for jeff_byte_serializer: table of frames with a sout
// scoreboard, plus reset, back-to-back and BIT_CYCLES=1 sequences.
module tb_jeff_byte_serializer;

   localparam int W  = 8;
   localparam int BC = 4;
   localparam int FL = (W + 2) * BC;

   logic         clk = 1'b0;
   logic         rst_bar = 1'b0;
   logic         load_en_bar = 1'b1;
   logic [W-1:0] d = '0;
   logic         ready, busy, sout, done;

   logic         load1 = 1'b1;
   logic [W-1:0] d1 = '0;
   logic         ready1, busy1, sout1, done1;

   int vecs = 0;
   int miss = 0;
   logic q[$];

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
      int         inject;
   } vec_t;

   vec_t tbl[4];

   always #5 clk = ~clk;

   jeff_byte_serializer #(.WIDTH(W), .BIT_CYCLES(BC)) dut (
      .clk(clk), .rst_bar(rst_bar), .load_en_bar(load_en_bar),
      .d(d), .ready(ready), .busy(busy), .sout(sout), .done(done)
   );

   jeff_byte_serializer #(.WIDTH(W), .BIT_CYCLES(1)) dut1 (
      .clk(clk), .rst_bar(rst_bar), .load_en_bar(load1),
      .d(d1), .ready(ready1), .busy(busy1), .sout(sout1), .done(done1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [7:0] word, input logic [9:0] frame,
                       input bit keep_low);
      for (int b = 0; b < 10; b++)
         for (int c = 0; c < BC; c++)
            q.push_back(frame[b]);
      d = word;
      load_en_bar = 1'b0;
      tick();
      if (!keep_low) load_en_bar = 1'b1;
   endtask

   task automatic run_frame(input string tag, input int inject);
      logic e;
      for (int i = 0; i < FL; i++) begin
         if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            e = 1'b1;
         end else begin
            e = q.pop_front();
         end
         chk({tag, "_sout"}, sout, e);
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_done_low"}, done, 0);
         if (i == inject) begin
            d = 8'hFF;
            load_en_bar = 1'b0;
         end else if (i == inject + 1) begin
            load_en_bar = 1'b1;
         end
         tick();
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_ready"}, ready, 1);
      chk({tag, "_idle_sout"}, sout, 1);
   endtask

   initial begin
      logic [9:0] f1;
      tbl[0] = '{8'hA5, 10'b1_10100101_0, -1};
      tbl[1] = '{8'h3C, 10'b1_00111100_0, 12};
      tbl[2] = '{8'hFF, 10'b1_11111111_0, -1};
      tbl[3] = '{8'h55, 10'b1_01010101_0, -1};

      d = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         load_en_bar = i[0];
         tick();
         chk("rst_sout", sout, 1);
         chk("rst_ready", ready, 1);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
      end
      load_en_bar = 1'b1;
      rst_bar = 1'b1;
      tick();
      chk("post_rst_ready", ready, 1);

      for (int t = 0; t < 4; t++) begin
         send(tbl[t].data, tbl[t].frame, 1'b0);
         run_frame($sformatf("tbl%0d", t), tbl[t].inject);
         tick();
         chk("done_clear", done, 0);
         for (int k = 0; k < 4; k++) begin
            chk("idle_sout", sout, 1);
            chk("idle_ready", ready, 1);
            tick();
         end
      end

      send(8'h01, 10'b1_00000001_0, 1'b1);
      d = 8'h80;
      run_frame("b2b_a", -1);
      send(8'h80, 10'b1_10000000_0, 1'b0);
      run_frame("b2b_b", -1);
      tick();
      chk("b2b_end_ready", ready, 1);

      send(8'h00, 10'b1_00000000_0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         chk("mid_sout", sout, q.pop_front());
         tick();
      end
      chk("mid_busy", busy, 1);
      #2 rst_bar = 1'b0;
      #1;
      chk("mid_rst_sout", sout, 1);
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_busy", busy, 0);
      q.delete();
      tick();
      tick();
      rst_bar = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mid_no_done", done, 0);
         chk("mid_idle_sout", sout, 1);
      end
      send(8'h55, 10'b1_01010101_0, 1'b0);
      run_frame("after_rst", -1);
      tick();

      f1 = 10'b1_11110000_0;
      d1 = 8'hF0;
      load1 = 1'b0;
      tick();
      load1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bc1_sout", sout1, f1[i]);
         chk("bc1_busy", busy1, 1);
         tick();
      end
      chk("bc1_done", done1, 1);
      chk("bc1_ready", ready1, 1);
      tick();
      chk("bc1_done_clear", done1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
